// File: rtl/amo_pkg.sv
// Shared types for the RV32A atomic sequencer: operation codes, FSM states
// and the values an SC writes back to rd.
package amo_pkg;

  typedef enum logic [3:0] {
    AMO_LR,
    AMO_SC,
    AMO_SWAP,
    AMO_ADD,
    AMO_XOR,
    AMO_AND,
    AMO_OR,
    AMO_MIN,
    AMO_MAX,
    AMO_MINU,
    AMO_MAXU
  } amoop_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } amo_state_t;

  localparam int unsigned SC_PASS = 0;
  localparam int unsigned SC_FAIL = 1;

endpackage

// File: rtl/amo_ctrl_if.sv
// Pipeline-side AMO request, snoop input and data-memory port of amo_ctrl.
// The slave modport is the sequencer; master is the pipeline plus memory.
interface amo_ctrl_if
  import amo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  amo_valid;
  amoop_t                amoop;
  logic [ADDR_WIDTH-1:0] amo_addr;
  logic [DATA_WIDTH-1:0] amo_src;
  logic                  snoop_valid;
  logic [ADDR_WIDTH-1:0] snoop_addr;
  logic                  stall;
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  amo_done;
  logic [DATA_WIDTH-1:0] amo_rdata;
  logic                  amo_misaligned;

  modport slave (
    input  amo_valid, amoop, amo_addr, amo_src, snoop_valid, snoop_addr,
           dm_gnt, dm_rvalid, dm_rdata,
    output stall, dm_req, dm_we, dm_addr, dm_wdata,
           amo_done, amo_rdata, amo_misaligned
  );

  modport master (
    output amo_valid, amoop, amo_addr, amo_src, snoop_valid, snoop_addr,
           dm_gnt, dm_rvalid, dm_rdata,
    input  stall, dm_req, dm_we, dm_addr, dm_wdata,
           amo_done, amo_rdata, amo_misaligned
  );

endinterface

// File: rtl/amo_alu.sv
// Combinational read-modify-write function: new memory value from the old
// value and rs2. LR/SC/SWAP simply pass rs2 through.
module amo_alu
  import amo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  amoop_t                op_i,
  input  logic [DATA_WIDTH-1:0] old_i,
  input  logic [DATA_WIDTH-1:0] src_i,
  output logic [DATA_WIDTH-1:0] new_o
);

  always_comb begin
    new_o = src_i;
    case (op_i)
      AMO_ADD:  new_o = old_i + src_i;
      AMO_XOR:  new_o = old_i ^ src_i;
      AMO_AND:  new_o = old_i & src_i;
      AMO_OR:   new_o = old_i | src_i;
      AMO_MIN:  new_o = ($signed(old_i) < $signed(src_i)) ? old_i : src_i;
      AMO_MAX:  new_o = ($signed(old_i) > $signed(src_i)) ? old_i : src_i;
      AMO_MINU: new_o = (old_i < src_i) ? old_i : src_i;
      AMO_MAXU: new_o = (old_i > src_i) ? old_i : src_i;
      default:  new_o = src_i;
    endcase
  end

endmodule

// File: rtl/amo_ctrl.sv
// RV32A sequencer: stalls the pipeline, runs the LR / SC / AMO memory
// sequence and owns the single LR/SC reservation.
module amo_ctrl
  import amo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  amo_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  amo_state_t            state_q, state_d;
  amoop_t                op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] src_q, src_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mis_q, mis_d;
  logic                  resv_valid_q, resv_valid_d;
  logic [ADDR_WIDTH-1:0] resv_addr_q, resv_addr_d;

  logic                  req, we;
  logic                  snoop_hit, addr_hit;
  logic [DATA_WIDTH-1:0] alu_new;

  amo_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op_i  (op_q),
    .old_i (rdata_q),
    .src_i (src_q),
    .new_o (alu_new)
  );

  // Word-granular compares; the XOR form keeps the byte-offset bits out of the match.
  assign snoop_hit = bus.snoop_valid && resv_valid_q &&
                     (((bus.snoop_addr ^ resv_addr_q) & WORD_MASK) == '0);
  assign addr_hit  = (((bus.amo_addr ^ resv_addr_q) & WORD_MASK) == '0);

  always_comb begin
    // NOTE: every _d and output gets a default first so no latch is inferred.
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    src_d        = src_q;
    rdata_d      = rdata_q;
    mis_d        = mis_q;
    resv_valid_d = resv_valid_q && !snoop_hit;
    resv_addr_d  = resv_addr_q;
    req          = 1'b0;
    we           = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.amo_valid) begin
          op_d   = bus.amoop;
          addr_d = bus.amo_addr & WORD_MASK;
          src_d  = bus.amo_src;
          mis_d  = |bus.amo_addr[1:0];
          if (|bus.amo_addr[1:0]) begin
            rdata_d = '0;
            state_d = DONE;
          end else if (bus.amoop == AMO_SC) begin
            // A snoop landing in this same cycle defeats the SC.
            if (resv_valid_q && !snoop_hit && addr_hit) begin
              state_d = WR_REQ;
            end else begin
              rdata_d = DATA_WIDTH'(SC_FAIL);
              state_d = DONE;
            end
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        req = 1'b1;
        if (bus.dm_gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.dm_rvalid) begin
          rdata_d = bus.dm_rdata;
          if (op_q == AMO_LR) begin
            resv_valid_d = 1'b1;
            resv_addr_d  = addr_q;
            state_d      = DONE;
          end else begin
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        req = 1'b1;
        we  = 1'b1;
        if (bus.dm_gnt) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (bus.dm_rvalid) begin
          if (op_q == AMO_SC) rdata_d = DATA_WIDTH'(SC_PASS);
          state_d = DONE;
        end
      end
      DONE: begin
        if (op_q == AMO_SC) resv_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= AMO_LR;
      addr_q       <= '0;
      src_q        <= '0;
      rdata_q      <= '0;
      mis_q        <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      // NOTE: non-blocking so every _q samples its _d from the same cycle.
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      src_q        <= src_d;
      rdata_q      <= rdata_d;
      mis_q        <= mis_d;
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end

  assign bus.stall          = bus.amo_valid && (state_q != DONE);
  assign bus.dm_req         = req;
  assign bus.dm_we          = we;
  assign bus.dm_addr        = req ? addr_q : '0;
  assign bus.dm_wdata       = we ? alu_new : '0;
  assign bus.amo_done       = (state_q == DONE);
  assign bus.amo_rdata      = rdata_q;
  assign bus.amo_misaligned = (state_q == DONE) && mis_q;

endmodule
